dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and access sequencer in front of the single-port data memory (1024 × 32-bit words, byte-addressed, word-indexed by address bits [31:2], synchronous read with registered RD, write on WE at posedge). It shares the memory between requester 0 (core load/store unit) and requester 1 (debug/loader port) with round-robin arbitration. It issues one memory command per cycle and sequences sub-word stores as read-modify-write. It also checks alignment and range and routes each response back to its owner.

## Interface
Parameters:
- DEPTH_WORDS, 1024: memory depth in words; byte addresses ≥ DEPTH_WORDS*4 are out of range.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset; synchronous and active-high.
- rN_req  in  1  request valid (N = 0, 1); held with its fields stable until rN_gnt.
- rN_we  in  1  1 = store, 0 = load.
- rN_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- rN_addr  in  32  byte address.
- rN_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rN_gnt  out  1  accept pulse, combinational; the request is consumed this cycle.
- rN_resp  out  1  one-cycle completion pulse for every accepted request.
- rN_rdata  out  32  raw aligned word for loads, valid with rN_resp; 0 for stores or errors.
- rN_err  out  1  valid with rN_resp: misaligned, illegal size, or out of range.
- mem_a  out  32  to memory A; word-aligned byte address, 0 when idle.
- mem_we  out  1  to memory WE.
- mem_wd  out  32  to memory WD.
- mem_rd  in  32  from memory RD.

## Operation
- FSM states:
  - IDLE: may grant.
  - RMW_WR: writing the merged word; no grant.
- Grant rule:
  - Grant only in IDLE and not in rst. If one requester is active, grant it.
  - If both are active, grant the one not granted last. The last-grant pointer resets to 1, so r0 wins the first contention.
  - At most one gnt per cycle.
- Load (any legal size): in the grant cycle, mem_a = {addr[31:2],2'b00} and mem_we = 0. The response carries mem_rd unmodified; the requester extracts the lane.
- Word store: in the grant cycle, mem_we = 1 and mem_wd = wdata.
- Byte/half store:
  - Grant cycle: issue a read of the word and latch owner, address, lane, size and wdata. Go to RMW_WR.
  - RMW_WR: mem_we = 1 to the same address, mem_wd = mem_rd with the lane replaced. Byte lane is addr[1:0] (bits 8·lane+7:8·lane). Half lane is addr[1] (bits 16·addr[1]+15:…). Return to IDLE.
- Error checks: half with addr[0] ≠ 0; word with addr[1:0] ≠ 0; size 11; addr ≥ DEPTH_WORDS*4.
- Error handling: the request is granted, no memory write is issued (mem_we = 0), and the response has err = 1 and rdata = 0.
- Response routing: the owner ID is registered at grant; only the owner's resp, rdata and err are driven, and the other port's outputs are 0.
- Reset (synchronous):
  - FSM → IDLE, pointer → 1, all pending responses dropped.
  - While rst is high: every gnt, resp and err = 0, every rdata = 0, mem_we = 0, mem_a = 0.
  - If rst is high in an RMW_WR cycle, the write is suppressed and memory is left unchanged.

## Timing
- Grant in cycle T.
- Load, word store, error: rN_resp in T+1. Load data in T+1 is mem_rd as registered at the T→T+1 edge.
- Sub-word store: write in T+1, rN_resp in T+2. No grant in T+1; the next grant is possible in T+2.
- Throughput: one load, word store or error per cycle, back-to-back; a response and a new grant may coincide.
- Load of a word stored in the previous cycle returns the new data, because the write commits at the T edge.
- The requester must hold req and its fields stable until gnt. Dropping req before gnt is legal and causes no access.

## Structure
- Package dmem_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - FSM state enum {IDLE, RMW_WR}
  - default DEPTH_WORDS
- Sub-module dmem_lane_merge (combinational): old word, wdata, size, addr[1:0] → merged word. Instantiated once, used in RMW_WR.
- The top level holds the arbiter pointer, FSM, owner/response registers and error checks.

## Test plan
- After reset, memory word 0 = 40: r0 word load at 0x0 → r0_gnt in T, r0_resp in T+1 with r0_rdata = 0x00000028, err = 0; r1 outputs stay 0.
- r0 and r1 both request in the first cycle after reset → r0 granted T, r1 granted T+1. Both re-request → r0 granted next (alternation continues).
- Word at 0x4 = 0x11223344; r1 SB at 0x5, wdata 0xAB → mem_we only in T+1 with mem_wd = 0x1122AB44, r1_resp in T+2. An r0 request raised in T+1 is granted in T+2.
- r0 SH at 0x3 → r0_err = 1 in T+1, rdata = 0, mem_we never asserted. r1 load at 0x1000 (out of range) → r1_err = 1.
- r0 word store 0xDEADBEEF to 0x8 in T, word load from 0x8 in T+1 → rdata = 0xDEADBEEF in T+2.
- SB to 0x4 with rst asserted in RMW_WR cycle → no mem_we, no resp, word 0x4 unchanged, next grant is to r0 after rst deasserts.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings and defaults for the data-memory arbiter slice.
package dmem_pkg;

  localparam int DEPTH_WORDS_DEFAULT = 1024;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    IDLE,
    RMW_WR
  } state_t;

endpackage

// File: rtl/dmem_lane_merge.sv
// Replaces the addressed byte or half lane of an old memory word with
// right-aligned store data; word size replaces the whole word.
module dmem_lane_merge
  import dmem_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  output logic [31:0] merged
);

  always_comb begin
    merged = old_word;
    case (size)
      SZ_BYTE: merged[{addr_lo, 3'b000} +: 8]        = wdata[7:0];
      SZ_HALF: merged[{addr_lo[1], 4'b0000} +: 16]   = wdata[15:0];
      SZ_WORD: merged                                 = wdata;
      default: merged                                 = old_word;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter for a single-port data memory; sub-word
// stores become a read in the grant cycle and a merged write in RMW_WR.
//
// Handshake: rN_req with its fields is held stable until rN_gnt; rN_gnt is
// combinational and consumes the request in that cycle. Every grant yields
// exactly one rN_resp pulse, one cycle later (two for sub-word stores).
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_req,
  input  logic        r0_we,
  input  logic [1:0]  r0_size,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  output logic        r0_gnt,
  output logic        r0_resp,
  output logic [31:0] r0_rdata,
  output logic        r0_err,
  input  logic        r1_req,
  input  logic        r1_we,
  input  logic [1:0]  r1_size,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  output logic        r1_gnt,
  output logic        r1_resp,
  output logic [31:0] r1_rdata,
  output logic        r1_err,
  output logic [31:0] mem_a,
  output logic        mem_we,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) * 33'd4;

  state_t      state, state_nxt;
  logic        last_ptr;
  logic        gnt_vld, gnt_id;
  logic        sel_we, sel_err, sel_subword;
  logic [1:0]  sel_size;
  logic [31:0] sel_addr, sel_wdata;

  logic        rmw_owner;
  logic [31:0] rmw_addr, rmw_wdata;
  logic [1:0]  rmw_size;
  logic [31:0] merged_word;

  logic        resp_vld, resp_owner, resp_err, resp_load, resp_live;
  logic [31:0] resp_data;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    if (!rst && state == IDLE) begin
      if (r0_req && r1_req) begin
        gnt_vld = 1'b1;
        gnt_id  = ~last_ptr;
      end else if (r0_req) begin
        gnt_vld = 1'b1;
      end else if (r1_req) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b1;
      end
    end
  end

  assign r0_gnt = gnt_vld & ~gnt_id;
  assign r1_gnt = gnt_vld & gnt_id;

  assign sel_we    = gnt_id ? r1_we    : r0_we;
  assign sel_size  = gnt_id ? r1_size  : r0_size;
  assign sel_addr  = gnt_id ? r1_addr  : r0_addr;
  assign sel_wdata = gnt_id ? r1_wdata : r0_wdata;

  always_comb begin
    sel_err = ({1'b0, sel_addr} >= ADDR_LIMIT);
    case (sel_size)
      SZ_BYTE: ;
      SZ_HALF: if (sel_addr[0]) sel_err = 1'b1;
      SZ_WORD: if (sel_addr[1:0] != 2'b00) sel_err = 1'b1;
      default: sel_err = 1'b1;
    endcase
  end

  // Illegal size is already an error, so only byte/half reach the RMW path.
  assign sel_subword = sel_we && !sel_err &&
                       (sel_size == SZ_BYTE || sel_size == SZ_HALF);

  dmem_lane_merge u_merge (
    .old_word (mem_rd),
    .wdata    (rmw_wdata),
    .size     (rmw_size),
    .addr_lo  (rmw_addr[1:0]),
    .merged   (merged_word)
  );

  always_comb begin
    state_nxt = state;
    mem_a     = 32'd0;
    mem_we    = 1'b0;
    mem_wd    = 32'd0;
    case (state)
      IDLE: begin
        if (gnt_vld && !sel_err) begin
          mem_a = {sel_addr[31:2], 2'b00};
          if (sel_we && sel_size == SZ_WORD) begin
            mem_we = 1'b1;
            mem_wd = sel_wdata;
          end
          if (sel_subword) state_nxt = RMW_WR;
        end
      end
      RMW_WR: begin
        state_nxt = IDLE;
        if (!rst) begin
          mem_a  = {rmw_addr[31:2], 2'b00};
          mem_we = 1'b1;
          mem_wd = merged_word;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_ptr   <= 1'b1;
      resp_vld   <= 1'b0;
      resp_owner <= 1'b0;
      resp_err   <= 1'b0;
      resp_load  <= 1'b0;
      rmw_owner  <= 1'b0;
      rmw_addr   <= 32'd0;
      rmw_size   <= 2'b00;
      rmw_wdata  <= 32'd0;
    end else begin
      state     <= state_nxt;
      resp_vld  <= 1'b0;
      resp_err  <= 1'b0;
      resp_load <= 1'b0;
      if (gnt_vld) begin
        last_ptr   <= gnt_id;
        resp_vld   <= !sel_subword;
        resp_owner <= gnt_id;
        resp_err   <= sel_err;
        resp_load  <= !sel_we && !sel_err;
        rmw_owner  <= gnt_id;
        rmw_addr   <= sel_addr;
        rmw_size   <= sel_size;
        rmw_wdata  <= sel_wdata;
      end else if (state == RMW_WR) begin
        resp_vld   <= 1'b1;
        resp_owner <= rmw_owner;
      end
    end
  end

  // Load data is the memory's registered output, passed through untouched.
  assign resp_live = resp_vld && !rst;
  assign resp_data = resp_load ? mem_rd : 32'd0;

  assign r0_resp  = resp_live && !resp_owner;
  assign r1_resp  = resp_live && resp_owner;
  assign r0_err   = r0_resp && resp_err;
  assign r1_err   = r1_resp && resp_err;
  assign r0_rdata = r0_resp ? resp_data : 32'd0;
  assign r1_rdata = r1_resp ? resp_data : 32'd0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Cycle-by-cycle directed vectors for dmem_arbiter against a behavioural
// single-port memory, plus a reset-during-RMW sequence.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } rq_t;

  typedef struct packed {
    logic        resp;
    logic        err;
    logic [31:0] rdata;
  } rs_t;

  typedef struct packed {
    rq_t         r0;
    rq_t         r1;
    logic        gnt0;
    logic        gnt1;
    logic        mwe;
    logic        ma_dc;
    logic [31:0] ma;
    logic [31:0] mwd;
    rs_t         s0;
    rs_t         s1;
  } vec_t;

  localparam rq_t NRQ = '0;
  localparam rs_t NRS = '0;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_mem;
  logic        r0_req, r0_we, r1_req, r1_we;
  logic [1:0]  r0_size, r1_size;
  logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic        r0_gnt, r0_resp, r0_err, r1_gnt, r1_resp, r1_err;
  logic [31:0] r0_rdata, r1_rdata;
  logic [31:0] mem_a, mem_wd, mem_rd;
  logic        mem_we;
  logic [31:0] mem [0:1023];

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  dmem_arbiter #(.DEPTH_WORDS(1024)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_size(r0_size), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_gnt(r0_gnt), .r0_resp(r0_resp),
    .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_req(r1_req), .r1_we(r1_we), .r1_size(r1_size), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_gnt(r1_gnt), .r1_resp(r1_resp),
    .r1_rdata(r1_rdata), .r1_err(r1_err),
    .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // Synchronous-read memory: write and registered read share the edge.
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'd0;
      mem[0]    <= 32'd40;
      mem[1]    <= 32'h1122_3344;
      mem[1023] <= 32'hCAFE_F00D;
      mem_rd    <= 32'd0;
    end else begin
      if (mem_we) mem[mem_a[11:2]] <= mem_wd;
      mem_rd <= mem[mem_a[11:2]];
    end
  end

  function automatic rq_t rq(logic we, logic [1:0] size, logic [31:0] addr,
                             logic [31:0] wdata);
    rq_t r;
    r.req = 1'b1; r.we = we; r.size = size; r.addr = addr; r.wdata = wdata;
    return r;
  endfunction

  function automatic rs_t rs(logic err, logic [31:0] rdata);
    rs_t r;
    r.resp = 1'b1; r.err = err; r.rdata = rdata;
    return r;
  endfunction

  function automatic vec_t mk(rq_t a, rq_t b, logic g0, logic g1, logic mwe,
                              logic ma_dc, logic [31:0] ma, logic [31:0] mwd,
                              rs_t s0, rs_t s1);
    vec_t v;
    v.r0 = a; v.r1 = b; v.gnt0 = g0; v.gnt1 = g1; v.mwe = mwe;
    v.ma_dc = ma_dc; v.ma = ma; v.mwd = mwd; v.s0 = s0; v.s1 = s1;
    return v;
  endfunction

  task automatic drive(rq_t a, rq_t b);
    r0_req = a.req; r0_we = a.we; r0_size = a.size; r0_addr = a.addr; r0_wdata = a.wdata;
    r1_req = b.req; r1_we = b.we; r1_size = b.size; r1_addr = b.addr; r1_wdata = b.wdata;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_resp(string tag, rs_t e0, rs_t e1);
    check({tag, " r0_resp"},  32'(r0_resp),  32'(e0.resp));
    check({tag, " r0_err"},   32'(r0_err),   32'(e0.err));
    check({tag, " r0_rdata"}, r0_rdata,      e0.rdata);
    check({tag, " r1_resp"},  32'(r1_resp),  32'(e1.resp));
    check({tag, " r1_err"},   32'(r1_err),   32'(e1.err));
    check({tag, " r1_rdata"}, r1_rdata,      e1.rdata);
  endtask

  initial begin
    // Columns: r0, r1, gnt0, gnt1, mem_we, mem_a don't-care, mem_a, mem_wd, r0 resp, r1 resp
    vecs.push_back(mk(rq(0,SZ_WORD,32'h0,0), rq(0,SZ_WORD,32'h4,0), 1,0,0,0,32'h0,0, NRS, NRS));
    vecs.push_back(mk(NRQ, rq(0,SZ_WORD,32'h4,0), 0,1,0,0,32'h4,0, rs(0,32'd40), NRS));
    vecs.push_back(mk(rq(0,SZ_WORD,32'h4,0), rq(0,SZ_WORD,32'h0,0), 1,0,0,0,32'h4,0, NRS, rs(0,32'h1122_3344)));
    vecs.push_back(mk(NRQ, rq(0,SZ_WORD,32'h0,0), 0,1,0,0,32'h0,0, rs(0,32'h1122_3344), NRS));
    vecs.push_back(mk(NRQ, NRQ, 0,0,0,0,32'h0,0, NRS, rs(0,32'd40)));
    vecs.push_back(mk(NRQ, rq(1,SZ_BYTE,32'h5,32'hAB), 0,1,0,0,32'h4,0, NRS, NRS));
    vecs.push_back(mk(rq(0,SZ_WORD,32'h0,0), NRQ, 0,0,1,0,32'h4,32'h1122_AB44, NRS, NRS));
    vecs.push_back(mk(rq(0,SZ_WORD,32'h0,0), NRQ, 1,0,0,0,32'h0,0, NRS, rs(0,0)));
    vecs.push_back(mk(rq(1,SZ_HALF,32'h3,32'h1234), NRQ, 1,0,0,1,32'h0,0, rs(0,32'd40), NRS));
    vecs.push_back(mk(NRQ, rq(0,SZ_WORD,32'h1000,0), 0,1,0,1,32'h0,0, rs(1,0), NRS));
    vecs.push_back(mk(rq(1,SZ_WORD,32'h8,32'hDEAD_BEEF), NRQ, 1,0,1,0,32'h8,32'hDEAD_BEEF, NRS, rs(1,0)));
    vecs.push_back(mk(rq(0,SZ_WORD,32'h8,0), NRQ, 1,0,0,0,32'h8,0, rs(0,0), NRS));
    vecs.push_back(mk(NRQ, rq(1,SZ_HALF,32'h6,32'h5566), 0,1,0,0,32'h4,0, rs(0,32'hDEAD_BEEF), NRS));
    vecs.push_back(mk(NRQ, NRQ, 0,0,1,0,32'h4,32'h5566_AB44, NRS, NRS));
    vecs.push_back(mk(rq(1,SZ_BYTE,32'hB,32'h77), rq(0,SZ_WORD,32'h4,0), 1,0,0,0,32'h8,0, NRS, rs(0,0)));
    vecs.push_back(mk(NRQ, rq(0,SZ_WORD,32'h4,0), 0,0,1,0,32'h8,32'h77AD_BEEF, NRS, NRS));
    vecs.push_back(mk(NRQ, rq(0,SZ_WORD,32'h4,0), 0,1,0,0,32'h4,0, rs(0,0), NRS));
    vecs.push_back(mk(NRQ, rq(0,SZ_WORD,32'h2,0), 0,1,0,1,32'h0,0, NRS, rs(0,32'h5566_AB44)));
    vecs.push_back(mk(rq(0,SZ_WORD,32'hFFC,0), NRQ, 1,0,0,0,32'hFFC,0, NRS, rs(1,0)));
    vecs.push_back(mk(rq(0,2'b11,32'h0,0), NRQ, 1,0,0,1,32'h0,0, rs(0,32'hCAFE_F00D), NRS));
    vecs.push_back(mk(NRQ, rq(0,SZ_BYTE,32'h9,0), 0,1,0,0,32'h8,0, rs(1,0), NRS));
    vecs.push_back(mk(NRQ, NRQ, 0,0,0,0,32'h0,0, NRS, rs(0,32'h77AD_BEEF)));

    rst = 1'b1;
    load_mem = 1'b1;
    drive(rq(0,SZ_WORD,32'h0,0), rq(0,SZ_WORD,32'h4,0));
    @(posedge clk); #1;
    load_mem = 1'b0;
    @(negedge clk);
    check("rst gnt0",   32'(r0_gnt), 32'd0);
    check("rst gnt1",   32'(r1_gnt), 32'd0);
    check("rst mem_we", 32'(mem_we), 32'd0);
    check("rst mem_a",  mem_a,       32'd0);
    check_resp("rst", NRS, NRS);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      drive(vecs[i].r0, vecs[i].r1);
      @(negedge clk);
      check({tag, " gnt0"},   32'(r0_gnt), 32'(vecs[i].gnt0));
      check({tag, " gnt1"},   32'(r1_gnt), 32'(vecs[i].gnt1));
      check({tag, " mem_we"}, 32'(mem_we), 32'(vecs[i].mwe));
      if (!vecs[i].ma_dc) check({tag, " mem_a"}, mem_a, vecs[i].ma);
      if (vecs[i].mwe) check({tag, " mem_wd"}, mem_wd, vecs[i].mwd);
      check_resp(tag, vecs[i].s0, vecs[i].s1);
      @(posedge clk); #1;
    end

    // Reset lands in the RMW_WR cycle of an r0 byte store; the pointer was
    // left at r0, so only a pointer reset lets r0 win the next contention.
    drive(rq(1,SZ_BYTE,32'h4,32'hEE), NRQ);
    @(negedge clk);
    check("rmwrst grant gnt0", 32'(r0_gnt), 32'd1);
    check("rmwrst grant mem_a", mem_a, 32'h4);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(NRQ, NRQ);
    @(negedge clk);
    check("rmwrst mem_we", 32'(mem_we), 32'd0);
    check("rmwrst mem_a",  mem_a,       32'd0);
    check_resp("rmwrst", NRS, NRS);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(rq(0,SZ_WORD,32'h0,0), rq(0,SZ_WORD,32'h4,0));
    @(negedge clk);
    check("post gnt0", 32'(r0_gnt), 32'd1);
    check("post gnt1", 32'(r1_gnt), 32'd0);
    check_resp("post", NRS, NRS);
    check("post word4", mem[1], 32'h5566_AB44);
    @(posedge clk); #1;
    drive(NRQ, NRQ);
    @(negedge clk);
    check_resp("post load", rs(0,32'd40), NRS);
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
